muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Owns no adder of its own. It drives an external alu instance through alu_opt/alu_a/alu_b and consumes alu_out: shift-add multiply, restoring divide, sign handling by ALU negation.
- Sits beside the EX stage. EX holds the pipeline while busy=1 and captures result on done.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  XLEN  operand A (dividend/multiplicand)
- rs2  in  XLEN  operand B (divisor/multiplier)
- kill  in  1  synchronous abort (pipeline flush)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result valid in that cycle
- result  out  XLEN  registered result; holds until next done
- alu_opt  out  5  ALU operation code
- alu_a  out  XLEN  ALU operand a
- alu_b  out  XLEN  ALU operand b
- alu_out  in  XLEN  ALU result (combinational, same cycle)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, all internal registers 0. alu_opt=ADD, alu_a=0, alu_b=0.
- ALU codes used:
  - ADD=5'b00000
  - SUB=5'b00001
  - PASS=5'b10001 (out=b)
- Operand signedness:
  - signed A: MULH, MULHSU, DIV, REM
  - signed B: MULH, DIV, REM
- States: IDLE -> NEG_A -> NEG_B -> ITER(x32) -> FIX_LO -> FIX_HI -> DONE -> IDLE.
- IDLE
  - start=1 latches op, rs1, rs2.
  - Special divide cases go straight to DONE:
    - divide by zero (rs2=0): quotient=all ones, remainder=rs1
    - signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0
- NEG_A
  - ALU SUB(0, A) if A is signed and negative; else PASS(A). Capture alu_out as |A|.
  - Record neg_a.
- NEG_B: same treatment for B; record neg_b.
- ITER, 32 cycles, counter 0..31.
  - Multiply: hi/lo product regs, lo initialised to |B|, hi to 0.
    - If lo[0]: ALU ADD(hi, |A|); carry = (alu_out < hi) unsigned, computed locally.
    - {c,hi,lo} <= {carry, sum_or_hi, lo} >> 1.
  - Divide: rem/quot regs, quot initialised to |A|, rem to 0.
    - Shifted {msb, rem'} = {rem, quot[31]}.
    - ALU SUB(rem', |B|); borrow = rem' < |B|.
    - If msb|~borrow: rem <= alu_out, quotient bit 1; else rem <= rem', bit 0.
- FIX_LO / FIX_HI: negate result if needed.
  - Multiply negates when neg_a^neg_b (64-bit two's complement):
    - FIX_LO: SUB(0, lo).
    - FIX_HI: ADD(~hi, lo_was_zero ? 1 : 0).
  - Quotient negates when neg_a^neg_b.
  - Remainder negates when neg_a (single SUB in FIX_LO; FIX_HI is PASS).
  - Non-negated paths use PASS.
- Result selection:
  - MUL selects the low word.
  - MULH* selects the high word.
- DONE: result register loads in this cycle's edge-prior; done=1 for exactly one cycle; next state IDLE.
- Latency:
  - Normal: start sampled at edge 0, done high in cycle 37 (edges 1..36 traverse 36 states).
  - Special divide cases: done high in cycle 1.
  - Latency is fixed and independent of operand values.
- Back-to-back: start in the DONE cycle is ignored. The next request is accepted in IDLE, one cycle after done.
- start while busy: ignored.
- kill: in any non-IDLE state, next state=IDLE, no done pulse, result unchanged. kill has priority over state transition and over start. kill in IDLE is a no-op.
- Reset mid-operation: immediate return to IDLE, no done.
- alu_opt/alu_a/alu_b are combinational from state/registers. They are ADD/0/0 in IDLE and DONE.

Decomposition:
- Shared package muldiv_pkg:
  - ALU opcode constants ALU_ADD, ALU_SUB, ALU_PASS (shared with the alu decoder)
  - funct3 op constants
  - state enum
- Sub-module muldiv_step: combinational per-iteration next-value logic (carry/borrow detect, shift) taking alu_out. The FSM stays in muldiv_seq.
- The alu is instantiated by the parent, not inside muldiv_seq.

Test Plan:
- MUL 7x6 -> done in cycle 37, result 42; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH -3 x 5 -> 0xFFFFFFFF; MUL -3 x 5 -> 0xFFFFFFF1; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV x/0 with rs1=5 -> 0xFFFFFFFF, done in cycle 1; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- kill asserted at ITER counter 10 -> IDLE next cycle, no done, result keeps prior value. New start then completes correctly.
- rst_n low mid-ITER -> busy=0, done=0 immediately. start during busy -> ignored, original result unaffected.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    // ALU operation codes, shared with the alu decoder
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_PASS = 5'b10001;   // out = b

    // funct3 encodings of the M-extension operations
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEG_A,
        ST_NEG_B,
        ST_ITER,
        ST_FIX_LO,
        ST_FIX_HI,
        ST_DONE
    } state_e;

    // Operand A is treated as two's complement for these operations
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Operand B is treated as two's complement for these operations
    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response and ALU-side signals between the EX stage and the sequencer.
// The EX side (master) also owns the shared ALU, so it drives alu_out.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      alu_opt;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_out;

    modport master (
        output start, op, rs1, rs2, kill, alu_out,
        input  busy, done, result, alu_opt, alu_a, alu_b
    );

    modport slave (
        input  start, op, rs1, rs2, kill, alu_out,
        output busy, done, result, alu_opt, alu_a, alu_b
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide. Chooses the ALU
// operation for the step and forms the next hi/lo pair from alu_out.
// For divide, hi holds the partial remainder and lo the quotient.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_mul,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] a_abs,
    input  logic [XLEN-1:0] b_abs,
    input  logic [XLEN-1:0] alu_out,
    output logic [4:0]      alu_opt,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN-1:0] rem_sh;
    logic            carry;
    logic            borrow;
    logic            take;

    // ALU request plus carry/borrow detection and the shift for one step
    always_comb begin
        alu_opt = ALU_ADD;
        alu_a   = '0;
        alu_b   = '0;
        hi_next = hi;
        lo_next = lo;
        rem_sh  = {hi[XLEN-2:0], lo[XLEN-1]};
        carry   = 1'b0;
        borrow  = 1'b0;
        take    = 1'b0;
        if (is_mul) begin
            // When the multiplier bit is clear the ALU just passes hi through,
            // so alu_out is the "sum or hi" term in both cases.
            if (lo[0]) begin
                alu_opt = ALU_ADD;
                alu_a   = hi;
                alu_b   = a_abs;
            end else begin
                alu_opt = ALU_PASS;
                alu_b   = hi;
            end
            carry   = lo[0] & (alu_out < hi);
            hi_next = {carry, alu_out[XLEN-1:1]};
            lo_next = {alu_out[0], lo[XLEN-1:1]};
        end else begin
            alu_opt = ALU_SUB;
            alu_a   = rem_sh;
            alu_b   = b_abs;
            borrow  = rem_sh < b_abs;
            // hi[XLEN-1] is the bit shifted out; if set the 33-bit remainder
            // always exceeds the divisor.
            take    = hi[XLEN-1] | ~borrow;
            hi_next = take ? alu_out : rem_sh;
            lo_next = {lo[XLEN-2:0], take};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer. Drives an external ALU to compute absolute
// operands, 32 shift-add / restoring-divide steps and a final sign fix-up.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic            lo_zero_q, lo_zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [4:0]      alu_opt;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;

    logic [4:0]      step_opt;
    logic [XLEN-1:0] step_a;
    logic [XLEN-1:0] step_b;
    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;

    logic            is_mul;
    logic            neg;

    assign is_mul = ~op_q[2];

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_mul  (is_mul),
        .hi      (hi_q),
        .lo      (lo_q),
        .a_abs   (a_q),
        .b_abs   (b_q),
        .alu_out (bus.alu_out),
        .alu_opt (step_opt),
        .alu_a   (step_a),
        .alu_b   (step_b),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            lo_zero_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            lo_zero_q <= lo_zero_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    // Next-state, datapath updates and ALU requests
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        lo_zero_d = lo_zero_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        alu_opt   = ALU_ADD;
        alu_a     = '0;
        alu_b     = '0;
        neg       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.kill) begin
                    op_d = bus.op;
                    a_d  = bus.rs1;
                    b_d  = bus.rs2;
                    if (bus.op[2] && (bus.rs2 == '0)) begin
                        // Divide by zero: all-ones quotient, dividend as remainder
                        state_d  = ST_DONE;
                        result_d = bus.op[1] ? bus.rs1 : '1;
                    end else if (bus.op[2] && !bus.op[0] &&
                                 (bus.rs1 == INT_MIN) && (bus.rs2 == '1)) begin
                        // Signed overflow: quotient INT_MIN, remainder zero
                        state_d  = ST_DONE;
                        result_d = bus.op[1] ? '0 : INT_MIN;
                    end else begin
                        state_d = ST_NEG_A;
                    end
                end
            end

            ST_NEG_A: begin
                neg     = op_signed_a(op_q) & a_q[XLEN-1];
                alu_opt = neg ? ALU_SUB : ALU_PASS;
                alu_b   = a_q;
                a_d     = bus.alu_out;
                neg_a_d = neg;
                state_d = ST_NEG_B;
            end

            ST_NEG_B: begin
                neg     = op_signed_b(op_q) & b_q[XLEN-1];
                alu_opt = neg ? ALU_SUB : ALU_PASS;
                alu_b   = b_q;
                b_d     = bus.alu_out;
                neg_b_d = neg;
                // Multiplier |B| or dividend |A| seeds the low register
                hi_d    = '0;
                lo_d    = is_mul ? bus.alu_out : a_q;
                cnt_d   = '0;
                state_d = ST_ITER;
            end

            ST_ITER: begin
                alu_opt = step_opt;
                alu_a   = step_a;
                alu_b   = step_b;
                hi_d    = step_hi;
                lo_d    = step_lo;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = ST_FIX_LO;
                end
            end

            ST_FIX_LO: begin
                if (is_mul || !op_q[1]) begin
                    // Low product word or quotient
                    neg       = neg_a_q ^ neg_b_q;
                    alu_b     = lo_q;
                    lo_d      = bus.alu_out;
                    lo_zero_d = (lo_q == '0);
                end else begin
                    // Remainder takes the dividend's sign
                    neg   = neg_a_q;
                    alu_b = hi_q;
                    hi_d  = bus.alu_out;
                end
                alu_opt = neg ? ALU_SUB : ALU_PASS;
                state_d = ST_FIX_HI;
            end

            ST_FIX_HI: begin
                if (is_mul && (neg_a_q ^ neg_b_q)) begin
                    // High word of the 64-bit negation: ~hi plus borrow-in from lo
                    alu_opt = ALU_ADD;
                    alu_a   = ~hi_q;
                    alu_b   = {{(XLEN-1){1'b0}}, lo_zero_q};
                end else begin
                    alu_opt = ALU_PASS;
                    alu_b   = (is_mul || op_q[1]) ? hi_q : lo_q;
                end
                hi_d     = bus.alu_out;
                result_d = (op_q == OP_MUL) ? lo_q : bus.alu_out;
                state_d  = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush abandons the operation without touching the result
        if (bus.kill && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.result  = result_q;
    assign bus.alu_opt = alu_opt;
    assign bus.alu_a   = alu_a;
    assign bus.alu_b   = alu_b;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vectors, multi-cycle corner sequences and
// randomized operations against an arithmetic reference model.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(.XLEN(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU owned by the parent
    always_comb begin
        case (bus.alu_opt)
            ALU_ADD:  bus.alu_out = bus.alu_a + bus.alu_b;
            ALU_SUB:  bus.alu_out = bus.alu_a - bus.alu_b;
            ALU_PASS: bus.alu_out = bus.alu_b;
            default:  bus.alu_out = '0;
        endcase
    end

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            OP_MUL:    begin p = ua * ub;              return p[31:0];  end
            OP_MULH:   begin p = sa * sb;              return p[63:32]; end
            OP_MULHSU: begin p = sa * longint'(ub);    return p[63:32]; end
            OP_MULHU:  begin p = ua * ub;              return p[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return MIN32;
                p = sa / sb; return p[31:0];
            end
            OP_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == OP_DIV || op == OP_REM) && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
        return 37;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        bus.op    = '0;
        bus.rs1   = '0;
        bus.rs2   = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present a request for exactly one rising edge
    task automatic kick(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Count cycles after the accepting edge until done; bounded
    task automatic wait_done(output int lat, output logic [31:0] res);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.done && lat < 200);
        if (!bus.done) check("done_timeout", {63'b0, bus.done}, 64'd1);
        res = bus.result;
    endtask

    task automatic run_and_check(input string name, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
        int          lat;
        logic [31:0] res;
        kick(op, a, b);
        wait_done(lat, res);
        $display("op=%0d a=%h b=%h -> res=%h lat=%0d (%s)", op, a, b, res, lat, name);
        check({name, "_res"}, res, exp);
        check({name, "_lat"}, lat, lat_exp);
        check({name, "_done_alu"}, {59'b0, bus.alu_opt} | bus.alu_a | bus.alu_b, 64'd0);
        @(negedge clk);
        check({name, "_done_pulse"}, {62'b0, bus.done, bus.busy}, 64'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        seen_done;
        n_total = 0;
        n_pass  = 0;

        vecs[0]  = '{"mul_7x6",      OP_MUL,    32'd7,        32'd6,        32'd42,       37};
        vecs[1]  = '{"mulhu_max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 37};
        vecs[2]  = '{"mulh_m3x5",    OP_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 37};
        vecs[3]  = '{"mul_m3x5",     OP_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 37};
        vecs[4]  = '{"mulhsu_m1x2",  OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 37};
        vecs[5]  = '{"div_m7_2",     OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 37};
        vecs[6]  = '{"rem_m7_2",     OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 37};
        vecs[7]  = '{"divu_100_7",   OP_DIVU,   32'd100,      32'd7,        32'd14,       37};
        vecs[8]  = '{"remu_100_7",   OP_REMU,   32'd100,      32'd7,        32'd2,        37};
        vecs[9]  = '{"div_5_0",      OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[10] = '{"rem_5_0",      OP_REM,    32'd5,        32'd0,        32'd5,        1};
        vecs[11] = '{"div_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[12] = '{"rem_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[13] = '{"divu_5_0",     OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[14] = '{"mulhu_min_x2", OP_MULHU,  32'h80000000, 32'd2,        32'd1,        37};
        vecs[15] = '{"div_min_1",    OP_DIV,    32'h80000000, 32'd1,        32'h80000000, 37};

        do_reset();
        check("rst_busy",   {63'b0, bus.busy}, 64'd0);
        check("rst_done",   {63'b0, bus.done}, 64'd0);
        check("rst_result", {32'b0, bus.result}, 64'd0);
        check("rst_alu",    {59'b0, bus.alu_opt} | bus.alu_a | bus.alu_b, 64'd0);

        foreach (vecs[i]) begin
            run_and_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // kill at iteration counter 10: known prior result, then abort
        run_and_check("pre_kill", OP_DIVU, 32'd100, 32'd7, 32'd14, 37);
        kick(OP_MUL, 32'd1234, 32'd5678);
        repeat (13) @(negedge clk);        // cycle 13 = ITER with counter 10
        bus.kill = 1'b1;
        @(posedge clk);
        #1 bus.kill = 1'b0;
        $display("kill at iter 10: busy=%0d done=%0d result=%h", bus.busy, bus.done, bus.result);
        check("kill_busy",   {63'b0, bus.busy}, 64'd0);
        check("kill_done",   {63'b0, bus.done}, 64'd0);
        check("kill_result", {32'b0, bus.result}, 64'd14);
        seen_done = 1'b0;
        repeat (45) begin
            @(negedge clk);
            seen_done |= bus.done;
        end
        check("kill_no_done", {63'b0, seen_done}, 64'd0);
        run_and_check("post_kill", OP_MUL, 32'd1234, 32'd5678, 32'd7006652, 37);

        // start while busy and in the DONE cycle are both ignored
        kick(OP_MUL, 32'd7, 32'd6);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.rs1   = 32'd9;
        bus.rs2   = 32'd0;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, res);
        $display("busy-start seq: res=%h", res);
        check("busy_start_res", {32'b0, res}, 64'd42);
        bus.start = 1'b1;                  // held only in the DONE cycle
        bus.op    = OP_DIVU;
        bus.rs1   = 32'd9;
        bus.rs2   = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("done_start_ignored", {63'b0, bus.busy}, 64'd0);

        // reset mid-ITER
        kick(OP_MULHU, 32'hDEADBEEF, 32'h12345678);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("reset mid-iter: busy=%0d done=%0d", bus.busy, bus.done);
        check("midrst_busy",   {63'b0, bus.busy}, 64'd0);
        check("midrst_done",   {63'b0, bus.done}, 64'd0);
        check("midrst_result", {32'b0, bus.result}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_and_check("post_rst", OP_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 37);

        // randomized operations, with operand values biased toward corners
        for (int k = 0; k < 60; k++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: a = 32'h0;
                1: a = MIN32;
                2: a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'd1;
                3: b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_and_check($sformatf("rnd%0d", k), op, a, b, ref_model(op, a, b), ref_lat(op, a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
